// File: rtl/iteration_mult_seq.sv
// Sequential shift-add mantissa multiplier.
// Retires ITER_BITS multiplier bits per cycle and delivers the full
// 2*WIDTH-bit unsigned product after WIDTH/ITER_BITS iterations.
// The start/done/kill handshake mirrors the div/sqrt iteration unit.
// WIDTH must be a multiple of ITER_BITS.
module iteration_mult_seq #(
  parameter int WIDTH     = 24,
  parameter int ITER_BITS = 1
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
  input  logic                 Start_SI,
  input  logic                 Kill_SI,
  input  logic [WIDTH-1:0]     Mant_a_DI,
  input  logic [WIDTH-1:0]     Mant_b_DI,
  output logic                 Ready_SO,
  output logic                 Done_SO,
  output logic [2*WIDTH-1:0]   Prod_DO
);

  localparam int N      = WIDTH / ITER_BITS;
  localparam int SUM_W  = WIDTH + ITER_BITS;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;

  logic [SUM_W-1:0]           a_ext;
  logic [SUM_W-1:0]           partial;
  logic [SUM_W-1:0]           sum;
  logic [SUM_W+WIDTH-1:0]     shifted;
  logic [2*WIDTH-1:0]         next_acc;

  // One iteration: add A times the low multiplier digit to the upper
  // accumulator half, then shift the whole accumulator right by one digit.
  always_comb begin
    a_ext   = {{ITER_BITS{1'b0}}, a_q};
    partial = '0;
    for (int j = 0; j < ITER_BITS; j++) begin
      if (b_q[j]) begin
        partial = partial + (a_ext << j);
      end
    end
    sum      = {{ITER_BITS{1'b0}}, acc_hi} + partial;
    shifted  = {sum, acc_lo} >> ITER_BITS;
    next_acc = shifted[2*WIDTH-1:0];
  end

  // Control FSM with the operand, accumulator and output registers.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      Ready_SO <= 1'b1;
      Done_SO  <= 1'b0;
      Prod_DO  <= '0;
    end else begin
      Done_SO <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_SI && !Kill_SI) begin
            a_q      <= Mant_a_DI;
            b_q      <= Mant_b_DI;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            state    <= BUSY;
            Ready_SO <= 1'b0;
          end
        end
        BUSY: begin
          if (Kill_SI) begin
            state    <= IDLE;
            Ready_SO <= 1'b1;
          end else begin
            b_q              <= b_q >> ITER_BITS;
            {acc_hi, acc_lo} <= next_acc;
            cnt              <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              Prod_DO  <= next_acc;
              Done_SO  <= 1'b1;
              state    <= IDLE;
              Ready_SO <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          Ready_SO <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iteration_mult_seq.sv
// Bench for iteration_mult_seq: three instances (ITER_BITS 1, 2, 4) sharing
// clock, reset, kill and operands, each with its own start line.
module tb_iteration_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start_1, start_2, start_4;
  logic        kill;
  logic [23:0] mant_a, mant_b;
  logic        ready_1, ready_2, ready_4;
  logic        done_1, done_2, done_4;
  logic [47:0] prod_1, prod_2, prod_4;

  int total = 0;
  int bad   = 0;

  logic [47:0] q1[$];
  logic [47:0] q2[$];
  logic [47:0] q4[$];
  logic [47:0] last1 = '0;

  iteration_mult_seq #(.WIDTH(24), .ITER_BITS(1)) dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start_1), .Kill_SI(kill),
    .Mant_a_DI(mant_a), .Mant_b_DI(mant_b),
    .Ready_SO(ready_1), .Done_SO(done_1), .Prod_DO(prod_1));

  iteration_mult_seq #(.WIDTH(24), .ITER_BITS(2)) dut2 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start_2), .Kill_SI(kill),
    .Mant_a_DI(mant_a), .Mant_b_DI(mant_b),
    .Ready_SO(ready_2), .Done_SO(done_2), .Prod_DO(prod_2));

  iteration_mult_seq #(.WIDTH(24), .ITER_BITS(4)) dut4 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start_4), .Kill_SI(kill),
    .Mant_a_DI(mant_a), .Mant_b_DI(mant_b),
    .Ready_SO(ready_4), .Done_SO(done_4), .Prod_DO(prod_4));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [47:0] model_mul(input logic [23:0] a, input logic [23:0] b);
    return {24'd0, a} * {24'd0, b};
  endfunction

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_1 = 1'b0; start_2 = 1'b0; start_4 = 1'b0; kill = 1'b0;
    mant_a = '0; mant_b = '0;
    #3;
    wait_cycle();
    wait_cycle();
    total++; if (ready_1 !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b want=1", ready_1); end
    total++; if (done_1 !== 1'b0) begin bad++; $display("FAIL reset_done1 got=%b want=0", done_1); end
    total++; if (prod_1 !== 48'd0) begin bad++; $display("FAIL reset_prod1 got=%h want=0", prod_1); end
    total++; if (ready_2 !== 1'b1 || done_2 !== 1'b0 || prod_2 !== 48'd0) begin
      bad++; $display("FAIL reset_dut2 got ready=%b done=%b prod=%h want 1/0/0", ready_2, done_2, prod_2); end
    total++; if (ready_4 !== 1'b1 || done_4 !== 1'b0 || prod_4 !== 48'd0) begin
      bad++; $display("FAIL reset_dut4 got ready=%b done=%b prod=%h want 1/0/0", ready_4, done_4, prod_4); end
    #2 rst_n = 1'b1;
    wait_cycle();
  endtask

  task automatic test_full_ones();
    logic [47:0] exp;
    mant_a = 24'hFFFFFF; mant_b = 24'hFFFFFF;
    q1.push_back(model_mul(mant_a, mant_b));
    start_1 = 1'b1;
    wait_cycle();
    start_1 = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      wait_cycle();
      total++; if (ready_1 !== ((c >= 24) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL ones_ready cycle=%0d got=%b", c, ready_1); end
      total++; if (done_1 !== ((c == 24) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL ones_done cycle=%0d got=%b", c, done_1); end
      if (done_1 === 1'b1 && q1.size() > 0) begin
        exp = q1.pop_front();
        total++; if (prod_1 !== exp) begin bad++; $display("FAIL ones_prod got=%h want=%h", prod_1, exp); end
        last1 = exp;
      end
    end
    total++; if (q1.size() != 0) begin bad++; $display("FAIL ones_missing got=%0d pending want=0", q1.size()); q1.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] exp;
    mant_a = 24'h800000; mant_b = 24'h800000;
    q1.push_back(model_mul(mant_a, mant_b));
    start_1 = 1'b1;
    wait_cycle();
    start_1 = 1'b0;
    for (int c = 1; c <= 49; c++) begin
      wait_cycle();
      if (c == 25) start_1 = 1'b0;
      total++; if (done_1 !== ((c == 24 || c == 49) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL b2b_done cycle=%0d got=%b", c, done_1); end
      total++; if (ready_1 !== ((c == 24 || c == 49) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL b2b_ready cycle=%0d got=%b", c, ready_1); end
      if (done_1 === 1'b1 && q1.size() > 0) begin
        exp = q1.pop_front();
        total++; if (prod_1 !== exp) begin bad++; $display("FAIL b2b_prod cycle=%0d got=%h want=%h", c, prod_1, exp); end
        last1 = exp;
      end
      if (c == 24) begin
        mant_a = 24'h000000; mant_b = 24'hABCDEF;
        q1.push_back(model_mul(mant_a, mant_b));
        start_1 = 1'b1;
      end
    end
    total++; if (q1.size() != 0) begin bad++; $display("FAIL b2b_missing got=%0d pending want=0", q1.size()); q1.delete(); end
  endtask

  task automatic test_kill();
    mant_a = 24'hC00000; mant_b = 24'hC00000;
    start_1 = 1'b1;
    wait_cycle();
    start_1 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      wait_cycle();
      if (c == 11) kill = 1'b0;
      total++; if (done_1 !== 1'b0) begin bad++; $display("FAIL kill_done cycle=%0d got=%b want=0", c, done_1); end
      total++; if (ready_1 !== ((c >= 11) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL kill_ready cycle=%0d got=%b", c, ready_1); end
      if (c == 10) kill = 1'b1;
    end
    total++; if (prod_1 !== last1) begin bad++; $display("FAIL kill_prod got=%h want=%h", prod_1, last1); end
  endtask

  task automatic test_kill_last();
    mant_a = 24'hFFFFFF; mant_b = 24'hFFFFFF;
    start_1 = 1'b1;
    wait_cycle();
    start_1 = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      wait_cycle();
      if (c == 24) kill = 1'b0;
      total++; if (done_1 !== 1'b0) begin bad++; $display("FAIL killlast_done cycle=%0d got=%b want=0", c, done_1); end
      total++; if (ready_1 !== ((c >= 24) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL killlast_ready cycle=%0d got=%b", c, ready_1); end
      if (c == 23) kill = 1'b1;
    end
    total++; if (prod_1 !== last1) begin bad++; $display("FAIL killlast_prod got=%h want=%h", prod_1, last1); end
  endtask

  task automatic test_kill_start_idle();
    mant_a = 24'h000003; mant_b = 24'h000005;
    kill = 1'b1; start_1 = 1'b1;
    wait_cycle();
    kill = 1'b0; start_1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total++; if (ready_1 !== 1'b1 || done_1 !== 1'b0) begin
        bad++; $display("FAIL killidle cycle=%0d got ready=%b done=%b want 1/0", c, ready_1, done_1); end
      wait_cycle();
    end
    total++; if (prod_1 !== last1) begin bad++; $display("FAIL killidle_prod got=%h want=%h", prod_1, last1); end
  endtask

  task automatic test_start_ignored();
    logic [47:0] exp;
    mant_a = 24'h123456; mant_b = 24'h654321;
    q1.push_back(model_mul(mant_a, mant_b));
    start_1 = 1'b1;
    wait_cycle();
    start_1 = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      wait_cycle();
      if (c == 6) start_1 = 1'b0;
      total++; if (done_1 !== ((c == 24) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL ignore_done cycle=%0d got=%b", c, done_1); end
      if (done_1 === 1'b1 && q1.size() > 0) begin
        exp = q1.pop_front();
        total++; if (prod_1 !== exp) begin bad++; $display("FAIL ignore_prod got=%h want=%h", prod_1, exp); end
        last1 = exp;
      end
      if (c == 5) begin
        mant_a = 24'hFFFFFF; mant_b = 24'hFFFFFF; start_1 = 1'b1;
      end
    end
    total++; if (q1.size() != 0) begin bad++; $display("FAIL ignore_missing got=%0d pending want=0", q1.size()); q1.delete(); end
  endtask

  task automatic test_iter_bits();
    logic [47:0] exp;
    mant_a = 24'hFFFFFF; mant_b = 24'h800001;
    q2.push_back(48'h8000007FFFFF);
    q4.push_back(48'h8000007FFFFF);
    start_2 = 1'b1; start_4 = 1'b1;
    wait_cycle();
    start_2 = 1'b0; start_4 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      wait_cycle();
      total++; if (done_2 !== ((c == 12) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL it2_done cycle=%0d got=%b", c, done_2); end
      total++; if (done_4 !== ((c == 6) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL it4_done cycle=%0d got=%b", c, done_4); end
      total++; if (ready_2 !== ((c >= 12) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL it2_ready cycle=%0d got=%b", c, ready_2); end
      total++; if (ready_4 !== ((c >= 6) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL it4_ready cycle=%0d got=%b", c, ready_4); end
      if (done_2 === 1'b1 && q2.size() > 0) begin
        exp = q2.pop_front();
        total++; if (prod_2 !== exp) begin bad++; $display("FAIL it2_prod got=%h want=%h", prod_2, exp); end
      end
      if (done_4 === 1'b1 && q4.size() > 0) begin
        exp = q4.pop_front();
        total++; if (prod_4 !== exp) begin bad++; $display("FAIL it4_prod got=%h want=%h", prod_4, exp); end
      end
    end
    total++; if (q2.size() != 0 || q4.size() != 0) begin
      bad++; $display("FAIL it_missing got=%0d/%0d pending want=0/0", q2.size(), q4.size()); q2.delete(); q4.delete(); end
  endtask

  task automatic test_async_reset();
    mant_a = 24'hFFFFFF; mant_b = 24'hFFFFFF;
    start_1 = 1'b1;
    wait_cycle();
    start_1 = 1'b0;
    for (int c = 1; c <= 7; c++) wait_cycle();
    rst_n = 1'b0;
    #1;
    total++; if (ready_1 !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", ready_1); end
    total++; if (done_1 !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", done_1); end
    total++; if (prod_1 !== 48'd0) begin bad++; $display("FAIL arst_prod1 got=%h want=0", prod_1); end
    total++; if (prod_2 !== 48'd0 || prod_4 !== 48'd0) begin
      bad++; $display("FAIL arst_prod24 got=%h/%h want=0/0", prod_2, prod_4); end
    last1 = '0;
    #2 rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      wait_cycle();
      if (done_1 !== 1'b0) begin
        total++; bad++; $display("FAIL arst_late_done cycle=%0d got=%b want=0", c, done_1);
      end
    end
    total++; if (ready_1 !== 1'b1 || prod_1 !== 48'd0) begin
      bad++; $display("FAIL arst_after got ready=%b prod=%h want 1/0", ready_1, prod_1); end
  endtask

  // Back-to-back random operations on the instance with the given ITER_BITS.
  task automatic test_random(input int sel, input int nops);
    logic [47:0] rq[$];
    logic [47:0] exp;
    logic        d;
    logic [47:0] p;
    int          lat;
    int          r;
    bit          got;
    lat = 24 / sel;
    for (int op = 0; op < nops; op++) begin
      mant_a = 24'($urandom);
      mant_b = 24'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0) mant_a = 24'h000000;
      if (r == 1) mant_a = 24'hFFFFFF;
      if (r == 2) mant_b = 24'h000000;
      if (r == 3) mant_b = 24'hFFFFFF;
      rq.push_back(model_mul(mant_a, mant_b));
      case (sel)
        1: start_1 = 1'b1;
        2: start_2 = 1'b1;
        default: start_4 = 1'b1;
      endcase
      wait_cycle();
      start_1 = 1'b0; start_2 = 1'b0; start_4 = 1'b0;
      got = 1'b0;
      for (int c = 1; c <= lat + 4; c++) begin
        wait_cycle();
        case (sel)
          1: begin d = done_1; p = prod_1; end
          2: begin d = done_2; p = prod_2; end
          default: begin d = done_4; p = prod_4; end
        endcase
        if (d === 1'b1) begin
          got = 1'b1;
          total++; if (c != lat) begin bad++; $display("FAIL rnd%0d_latency op=%0d got=%0d want=%0d", sel, op, c, lat); end
          exp = rq.pop_front();
          total++; if (p !== exp) begin bad++; $display("FAIL rnd%0d_prod op=%0d got=%h want=%h", sel, op, p, exp); end
          break;
        end
      end
      if (!got) begin
        total++; bad++;
        $display("FAIL rnd%0d_timeout op=%0d got=no done want=done", sel, op);
        rq.delete();
        kill = 1'b1; wait_cycle(); kill = 1'b0;
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_full_ones();
    test_back_to_back();
    test_kill();
    test_kill_last();
    test_kill_start_idle();
    test_start_ignored();
    test_iter_bits();
    test_async_reset();
    test_random(1, 300);
    test_random(2, 300);
    test_random(4, 300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
